// File: rtl/gcm_pkg.sv
// Shared GCM widths, the 128-bit block type and the GHASH controller state encoding.
package gcm_pkg;
   localparam int BLK_W = 128;
   localparam int LEN_W = 64;

   typedef logic [127:0] gcm_blk_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ACCEPT,
      S_MULT,
      S_LEN_WAIT,
      S_LEN_MULT,
      S_DONE,
      S_DRAIN
   } ghash_state_e;
endpackage

// File: rtl/gcm_ghash_ctrl.sv
// GHASH sequencer: feeds Y^X to the shared GF(2^128) multiplier, strobes the length counter, closes with {len(A),len(C)}.
// Build option GCM_ORDER_CHK_EN drops AAD blocks arriving after ciphertext and raises sticky err_o.
module gcm_ghash_ctrl
   import gcm_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start_i,
   input  logic               abort_i,
   input  logic               blk_vld_i,
   output logic               blk_rdy_o,
   input  logic               blk_is_ct_i,
   input  logic [BLK_W-1:0]   blk_data_i,
   input  logic               fin_i,
   output logic               mult_req_o,
   output logic [BLK_W-1:0]   mult_x_o,
   input  logic               mult_done_i,
   input  logic [BLK_W-1:0]   mult_z_i,
   output logic               ctr_rst_o,
   output logic               ctr_vld_a_o,
   output logic               ctr_vld_c_o,
   input  logic [2*LEN_W-1:0] ctr_len_i,
   output logic [BLK_W-1:0]   tag_o,
   output logic               tag_vld_o,
   input  logic               tag_ack_i,
   output logic               err_o
);

   ghash_state_e r_state;
   gcm_blk_t     r_y;
   gcm_blk_t     r_x;
   gcm_blk_t     r_tag;
   logic         r_req;
   logic         r_tag_vld;
   logic         r_err;
   logic         r_fin_pend;
   logic         r_seen_ct;

   logic w_abort;
   logic w_hs;
   logic w_drop;
   logic w_take;

   // Abort is meaningless in DRAIN: the outstanding product must still be absorbed.
   assign w_abort   = abort_i && (r_state != S_DRAIN);
   assign blk_rdy_o = (r_state == S_ACCEPT) && !abort_i;
   assign w_hs      = blk_vld_i && blk_rdy_o;

`ifdef GCM_ORDER_CHK_EN
   assign w_drop = w_hs && !blk_is_ct_i && r_seen_ct;
`else
   assign w_drop = 1'b0;
`endif
   assign w_take = w_hs && !w_drop;

   assign ctr_rst_o   = w_abort || ((r_state == S_IDLE) && start_i);
   assign ctr_vld_c_o = w_take && blk_is_ct_i;
   assign ctr_vld_a_o = w_take && !blk_is_ct_i;

   assign mult_req_o = r_req;
   assign mult_x_o   = r_x;
   assign tag_o      = r_tag;
   assign tag_vld_o  = r_tag_vld;
   assign err_o      = r_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_y        <= '0;
         r_x        <= '0;
         r_tag      <= '0;
         r_req      <= 1'b0;
         r_tag_vld  <= 1'b0;
         r_err      <= 1'b0;
         r_fin_pend <= 1'b0;
         r_seen_ct  <= 1'b0;
      end else begin
         r_req <= 1'b0;
         if (w_abort) begin
            r_tag_vld <= 1'b0;
            // A product completing in the abort cycle leaves nothing to drain.
            if (((r_state == S_MULT) || (r_state == S_LEN_MULT)) && !mult_done_i)
               r_state <= S_DRAIN;
            else
               r_state <= S_IDLE;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (start_i) begin
                     r_y        <= '0;
                     r_seen_ct  <= 1'b0;
                     r_fin_pend <= 1'b0;
                     r_err      <= 1'b0;
                     r_state    <= S_ACCEPT;
                  end
               end
               S_ACCEPT: begin
                  if (w_take) begin
                     r_x        <= r_y ^ blk_data_i;
                     r_req      <= 1'b1;
                     r_seen_ct  <= r_seen_ct | blk_is_ct_i;
                     r_fin_pend <= fin_i;
                     r_state    <= S_MULT;
                  end else begin
                     if (w_drop)
                        r_err <= 1'b1;
                     if (fin_i)
                        r_state <= S_LEN_WAIT;
                  end
               end
               S_MULT: begin
                  if (mult_done_i) begin
                     r_y     <= mult_z_i;
                     r_state <= r_fin_pend ? S_LEN_WAIT : S_ACCEPT;
                  end
               end
               S_LEN_WAIT: begin
                  r_x     <= r_y ^ ctr_len_i;
                  r_req   <= 1'b1;
                  r_state <= S_LEN_MULT;
               end
               S_LEN_MULT: begin
                  if (mult_done_i) begin
                     r_tag     <= mult_z_i;
                     r_tag_vld <= 1'b1;
                     r_state   <= S_DONE;
                  end
               end
               S_DONE: begin
                  if (tag_ack_i) begin
                     r_tag_vld <= 1'b0;
                     r_state   <= S_IDLE;
                  end
               end
               S_DRAIN: begin
                  if (mult_done_i)
                     r_state <= S_IDLE;
               end
               default: r_state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_gcm_ghash_ctrl.sv
// Bench for gcm_ghash_ctrl: behavioural multiplier and length counter, table of messages checked against a GHASH reference.
`timescale 1ns/1ps
module tb_gcm_ghash_ctrl;
   import gcm_pkg::*;

   localparam gcm_blk_t H = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;
`ifdef GCM_ORDER_CHK_EN
   localparam bit ORDER_CHK = 1'b1;
`else
   localparam bit ORDER_CHK = 1'b0;
`endif

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic           start_i = 1'b0, abort_i = 1'b0, blk_vld_i = 1'b0, blk_is_ct_i = 1'b0, fin_i = 1'b0;
   gcm_blk_t       blk_data_i = '0;
   logic           blk_rdy_o, mult_req_o, ctr_rst_o, ctr_vld_a_o, ctr_vld_c_o, tag_vld_o, err_o;
   gcm_blk_t       mult_x_o, tag_o;
   logic           mult_done_i = 1'b0;
   gcm_blk_t       mult_z_i = '0;
   logic           tag_ack_i = 1'b0;
   logic [63:0]    len_a, len_c;
   logic [127:0]   ctr_len_i;

   int checks = 0, errors = 0;
   int cnt_a = 0, cnt_c = 0, cnt_rst = 0, cnt_viol = 0;
   int lat = 1;
   gcm_blk_t xlog[$];
   gcm_blk_t mx;

   always #5 clk = ~clk;

   gcm_ghash_ctrl dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .abort_i(abort_i),
      .blk_vld_i(blk_vld_i), .blk_rdy_o(blk_rdy_o), .blk_is_ct_i(blk_is_ct_i), .blk_data_i(blk_data_i),
      .fin_i(fin_i), .mult_req_o(mult_req_o), .mult_x_o(mult_x_o), .mult_done_i(mult_done_i),
      .mult_z_i(mult_z_i), .ctr_rst_o(ctr_rst_o), .ctr_vld_a_o(ctr_vld_a_o), .ctr_vld_c_o(ctr_vld_c_o),
      .ctr_len_i(ctr_len_i), .tag_o(tag_o), .tag_vld_o(tag_vld_o), .tag_ack_i(tag_ack_i), .err_o(err_o)
   );

   // GF(2^128) product in GCM bit order.
   function automatic gcm_blk_t gf_mul(input gcm_blk_t x, input gcm_blk_t y);
      gcm_blk_t z, v;
      z = '0;
      v = y;
      for (int i = 0; i < 128; i++) begin
         if (x[127-i]) z = z ^ v;
         v = v[0] ? ((v >> 1) ^ {8'he1, 120'd0}) : (v >> 1);
      end
      return z;
   endfunction

   // Length counter: bit counts of AAD and CT, cleared on ctr_rst_o.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         len_a <= '0;
         len_c <= '0;
      end else if (ctr_rst_o) begin
         len_a <= '0;
         len_c <= '0;
      end else begin
         if (ctr_vld_a_o) len_a <= len_a + 64'd128;
         if (ctr_vld_c_o) len_c <= len_c + 64'd128;
      end
   end
   assign ctr_len_i = {len_a, len_c};

   always @(negedge clk) begin
      if (ctr_rst_o) cnt_rst++;
      if (ctr_vld_a_o) cnt_a++;
      if (ctr_vld_c_o) cnt_c++;
      if (ctr_rst_o && (ctr_vld_a_o || ctr_vld_c_o)) cnt_viol++;
   end

   // Multiplier: completes 'lat' cycles after the request cycle.
   always begin
      @(negedge clk);
      if (mult_req_o) begin
         mx = mult_x_o;
         xlog.push_back(mx);
         repeat (lat) @(posedge clk);
         #1;
         mult_z_i    = gf_mul(mx, H);
         mult_done_i = 1'b1;
         @(posedge clk);
         #1;
         mult_done_i = 1'b0;
      end
   end

   typedef struct {
      int              nblk;
      logic [7:0]      ct_mask;
      int              lat;
      bit              fin_sep;
      gcm_blk_t [7:0]  blk;
      gcm_blk_t        exp_tag;
      logic [127:0]    exp_len;
      gcm_blk_t        exp_lenx;
      bit              exp_err;
      int              exp_na;
      int              exp_nc;
   } vec_t;

   function automatic vec_t mk(input int n, input logic [7:0] m, input int l, input bit fs);
      vec_t v;
      v.nblk = n; v.ct_mask = m; v.lat = l; v.fin_sep = fs;
      for (int i = 0; i < 8; i++) v.blk[i] = {$urandom, $urandom, $urandom, $urandom};
      return v;
   endfunction

   // Reference GHASH over the blocks that are hashed, in arrival order.
   function automatic vec_t fill_exp(input vec_t v);
      vec_t     r;
      gcm_blk_t y;
      bit       seen;
      r = v; y = '0; seen = 1'b0;
      r.exp_err = 1'b0; r.exp_na = 0; r.exp_nc = 0;
      for (int i = 0; i < v.nblk; i++) begin
         if (ORDER_CHK && !v.ct_mask[i] && seen) begin
            r.exp_err = 1'b1;
            continue;
         end
         seen = seen | v.ct_mask[i];
         y = gf_mul(y ^ v.blk[i], H);
         if (v.ct_mask[i]) r.exp_nc++; else r.exp_na++;
      end
      r.exp_len  = {64'(r.exp_na * 128), 64'(r.exp_nc * 128)};
      r.exp_lenx = y ^ r.exp_len;
      r.exp_tag  = gf_mul(r.exp_lenx, H);
      return r;
   endfunction

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_rdy(input string nm);
      int t;
      t = 0;
      @(negedge clk);
      while (!blk_rdy_o && t < 100) begin
         @(negedge clk);
         t++;
      end
      if (!blk_rdy_o) begin
         checks++; errors++;
         $display("FAIL %s blk_rdy timeout: got 0 expected 1", nm);
      end
   endtask

   task automatic wait_tag(input string nm);
      int t;
      t = 0;
      while (!tag_vld_o && t < 200) begin
         step();
         t++;
      end
      if (!tag_vld_o) begin
         checks++; errors++;
         $display("FAIL %s tag_vld timeout: got 0 expected 1", nm);
      end
   endtask

   task automatic send_blk(input gcm_blk_t d, input logic ct, input logic fin, input string nm);
      blk_vld_i = 1'b1; blk_data_i = d; blk_is_ct_i = ct; fin_i = fin;
      wait_rdy(nm);
      step();
   endtask

   task automatic run_vec(input vec_t v, input string nm);
      int b_a, b_c, b_r, b_v, b_x;
      gcm_blk_t lx;
      b_a = cnt_a; b_c = cnt_c; b_r = cnt_rst; b_v = cnt_viol; b_x = xlog.size();
      lat = v.lat;
      start_i = 1'b1; step(); start_i = 1'b0;
      for (int i = 0; i < v.nblk; i++)
         send_blk(v.blk[i], v.ct_mask[i], (i == v.nblk - 1) && !v.fin_sep, nm);
      blk_vld_i = 1'b0; fin_i = 1'b0;
      if (v.nblk == 0 || v.fin_sep) begin
         fin_i = 1'b1;
         wait_rdy(nm);
         step();
         fin_i = 1'b0;
      end
      wait_tag(nm);
      lx = (xlog.size() > b_x) ? xlog[xlog.size()-1] : '0;
      check({nm, " tag"}, tag_o, v.exp_tag);
      check({nm, " len"}, ctr_len_i, v.exp_len);
      check({nm, " len_x"}, lx, v.exp_lenx);
      check({nm, " n_mult"}, 128'(xlog.size() - b_x), 128'(v.exp_na + v.exp_nc + 1));
      check({nm, " n_aad"}, 128'(cnt_a - b_a), 128'(v.exp_na));
      check({nm, " n_ct"}, 128'(cnt_c - b_c), 128'(v.exp_nc));
      check({nm, " err"}, err_o, v.exp_err);
      // start_i must be ignored while the tag waits for its acknowledge.
      start_i = 1'b1; repeat (3) step(); start_i = 1'b0;
      check({nm, " tag_vld held"}, tag_vld_o, 1'b1);
      check({nm, " tag held"}, tag_o, v.exp_tag);
      check({nm, " n_rst"}, 128'(cnt_rst - b_r), 128'd1);
      check({nm, " rst_overlap"}, 128'(cnt_viol - b_v), 128'd0);
      tag_ack_i = 1'b1; step(); tag_ack_i = 1'b0;
      check({nm, " tag_vld after ack"}, tag_vld_o, 1'b0);
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t tbl[10];
      vec_t tv;
      gcm_blk_t a_blk, b_blk;
      bit bad_rdy, bad_x;
      int b_c, b_r;

      tbl[0] = fill_exp(mk(0, 8'h00, 2, 1'b0));
      tv = mk(1, 8'h01, 3, 1'b0);
      tv.blk[0] = 128'h0388dace60b6a392f328c2b971b2fe78;
      tbl[1] = fill_exp(tv);
      tbl[2] = fill_exp(mk(5, 8'b0001_1100, 1, 1'b0));
      tbl[3] = fill_exp(mk(5, 8'b0001_1100, 7, 1'b1));
      tbl[4] = fill_exp(mk(2, 8'b0000_0001, 2, 1'b0));
      for (int i = 5; i < 10; i++)
         tbl[i] = fill_exp(mk(int'($urandom_range(1, 8)), 8'($urandom), int'($urandom_range(1, 6)),
                              1'($urandom_range(0, 1))));

      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("reset tag_vld", tag_vld_o, 1'b0);
      check("reset tag", tag_o, '0);
      check("reset mult_req", mult_req_o, 1'b0);
      check("reset mult_x", mult_x_o, '0);
      check("reset rdy", blk_rdy_o, 1'b0);
      check("reset ctr strobes", {ctr_rst_o, ctr_vld_a_o, ctr_vld_c_o}, 3'b000);
      check("reset err", err_o, 1'b0);
      step();

      for (int i = 0; i < 10; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

      // Block valid held through a long multiply, then abort while the tag is pending.
      a_blk = {$urandom, $urandom, $urandom, $urandom};
      b_blk = {$urandom, $urandom, $urandom, $urandom};
      tv = mk(2, 8'b11, 7, 1'b0);
      tv.blk[0] = a_blk; tv.blk[1] = b_blk;
      tv = fill_exp(tv);
      lat = 7; b_c = cnt_c; b_r = cnt_rst;
      start_i = 1'b1; step(); start_i = 1'b0;
      send_blk(a_blk, 1'b1, 1'b0, "hold");
      blk_data_i = b_blk; fin_i = 1'b1;
      bad_rdy = 1'b0; bad_x = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (blk_rdy_o) bad_rdy = 1'b1;
         if (mult_x_o !== a_blk) bad_x = 1'b1;
      end
      check("hold rdy low in MULT", bad_rdy, 1'b0);
      check("hold mult_x stable", bad_x, 1'b0);
      check("hold single ct strobe", 128'(cnt_c - b_c), 128'd1);
      wait_rdy("hold");
      step();
      blk_vld_i = 1'b0; fin_i = 1'b0;
      wait_tag("hold");
      check("hold tag", tag_o, tv.exp_tag);
      abort_i = 1'b1; step(); abort_i = 1'b0;
      check("abort in DONE tag_vld", tag_vld_o, 1'b0);
      check("abort in DONE n_rst", 128'(cnt_rst - b_r), 128'd2);
      step();

      // Abort during a multiply: the late product must be absorbed, not hashed.
      lat = 5; b_r = cnt_rst;
      start_i = 1'b1; step(); start_i = 1'b0;
      send_blk({$urandom, $urandom, $urandom, $urandom}, 1'b0, 1'b0, "abort");
      blk_vld_i = 1'b0;
      step(); step();
      abort_i = 1'b1; step(); abort_i = 1'b0;
      @(negedge clk);
      check("abort in MULT n_rst", 128'(cnt_rst - b_r), 128'd2);
      check("abort in MULT rdy", blk_rdy_o, 1'b0);
      repeat (8) step();
      check("abort tag_vld", tag_vld_o, 1'b0);
      run_vec(tbl[3], "after_abort");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/gcm_ghash_ctrl.md
Name: gcm_ghash_ctrl

Overview:
Sequences one GHASH computation for AES-GCM. Accepts 128-bit AAD and ciphertext blocks over a valid/ready stream and drives the shared GF(2^128) multiplier with Y xor X. Drives the per-message bit-length counter's reset and valid strobes. Closes each message by hashing the length block {len(A),len(C)}; the block sits between the AES-CTR datapath and the tag XOR stage.

Parameters:
BLK_W, 128, block and accumulator width (fixed by GCM; not to be overridden)
LEN_W, 64, width of each half of the length block

Ports:
clk  in  1  clock
rst_n  in  1  reset: asynchronous, active-low
start_i  in  1  begin new message; honoured only in IDLE
abort_i  in  1  cancel current message from any state
blk_vld_i  in  1  input block valid
blk_rdy_o  out  1  input block ready
blk_is_ct_i  in  1  1 = ciphertext block, 0 = AAD block
blk_data_i  in  BLK_W  input block
fin_i  in  1  end of message; may coincide with last block
mult_req_o  out  1  one-cycle multiply request
mult_x_o  out  BLK_W  multiplier operand; H is held inside the multiplier
mult_done_i  in  1  one-cycle multiply completion
mult_z_i  in  BLK_W  product, valid with mult_done_i
ctr_rst_o  out  1  length counter clear
ctr_vld_a_o  out  1  AAD length +128
ctr_vld_c_o  out  1  CT length +128
ctr_len_i  in  2*LEN_W  {len_a,len_c} from length counter
tag_o  out  BLK_W  final GHASH value S
tag_vld_o  out  1  S valid, held until tag_ack_i
tag_ack_i  in  1  S consumed
err_o  out  1  sticky order error (only with GCM_ORDER_CHK_EN)

Behaviour:
- Reset values: all outputs 0. Y=0, state IDLE, fin_pend=0, seen_ct=0.
- States: IDLE, ACCEPT, MULT, LEN_WAIT, LEN_MULT, DONE, DRAIN.
- IDLE, start_i=1:
  - ctr_rst_o=1 for one cycle; Y<=0, seen_ct<=0, fin_pend<=0.
  - Next state ACCEPT.
- ACCEPT:
  - blk_rdy_o=1.
  - Handshake on blk_vld_i&blk_rdy_o: mult_x_o<=Y^blk_data_i registered; mult_req_o pulses the next cycle.
  - Same handshake cycle: ctr_vld_c_o=blk_is_ct_i, ctr_vld_a_o=!blk_is_ct_i, seen_ct|=blk_is_ct_i; fin_pend<=fin_i. Next state MULT.
  - fin_i=1 with no handshake: next state LEN_WAIT. This covers the empty message.
- MULT:
  - blk_rdy_o=0; mult_x_o held stable.
  - On mult_done_i: Y<=mult_z_i; next state LEN_WAIT if fin_pend, else ACCEPT.
  - Multiplier latency is arbitrary, minimum 1 cycle.
- LEN_WAIT:
  - Exactly one cycle, so the counter's final strobe has landed.
  - Latch mult_x_o<=Y^ctr_len_i and pulse mult_req_o; next state LEN_MULT.
- LEN_MULT, on mult_done_i: tag_o<=mult_z_i, tag_vld_o<=1; next state DONE.
- DONE:
  - tag_vld_o and tag_o held.
  - tag_ack_i: tag_vld_o<=0; next state IDLE.
  - start_i is ignored until IDLE.
- abort_i:
  - Highest priority; ctr_rst_o pulses and tag_vld_o<=0.
  - From MULT or LEN_MULT: go to DRAIN, wait for the outstanding mult_done_i, discard the product, then go to IDLE.
  - From any other state: go directly to IDLE.
  - abort_i in DRAIN is ignored.
- mult_done_i outside MULT, LEN_MULT or DRAIN is ignored.
- Exactly one of ctr_vld_a_o/ctr_vld_c_o fires per accepted block. ctr_rst_o never coincides with either strobe.
- Only full 128-bit blocks are handled; padding of partial blocks is the producer's job.

Optional Feature:
GCM_ORDER_CHK_EN:
- Defined: an AAD block accepted while seen_ct=1 sets err_o (sticky until the next start_i). The block is consumed and dropped: no counter strobe, no multiply, stay in ACCEPT.
- Undefined: err_o tied 0; blocks of either type are hashed in arrival order.

Decomposition:
- Package gcm_pkg:
  - BLK_W and LEN_W constants
  - typedef gcm_blk_t (logic [127:0])
  - enum ghash_state_e for the seven states
- No sub-module; the controller instantiates nothing. It is wired beside the existing length counter and multiplier at the gcm top level.

Test Plan:
1. Empty message: start_i, then fin_i with no blocks -> ctr_rst_o one pulse, len block 0, mult_x_o=0, tag_o=mult_z_i of model; with a real multiplier, tag_o=0.
2. One CT block 0x0388dace60b6a392f328c2b971b2fe78 with fin_i in the same cycle -> ctr_vld_c_o one pulse; second mult_x_o = Y1 ^ 128'h0000_0000_0000_0000_0000_0000_0000_0080.
3. Two AAD blocks then three CT blocks, model multiplier latency 1 and 7 -> ctr_len_i={64'd256,64'd384} at LEN_WAIT; tag_o matches the bench GHASH golden model.
4. blk_vld_i held high through MULT -> blk_rdy_o=0, no extra counter strobe, mult_x_o stable until mult_done_i.
5. abort_i during MULT with latency 5 -> DRAIN absorbs mult_done_i; Y unchanged by it; next start_i gives tag_o equal to a fresh run.
6. GCM_ORDER_CHK_EN: CT block then AAD block -> err_o=1, ctr_len_i={0,128}, tag_o equals the CT-only result.
